// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer handshakes, FIFO write port and threshold config
interface fifo_write_arbiter_if;
  logic       valid0, ready0, valid1, ready1;
  logic [7:0] data0, data1, data_in;
  logic       fifo_full, fifo_empty, write_enable;
  logic [5:0] full_tresh, cfg_thresh;
  logic       cfg_load, cfg_pending;
  logic [1:0] grant;
  logic [15:0] cnt0, cnt1;
  modport master (
    output valid0, data0, valid1, data1, fifo_full, fifo_empty, cfg_thresh, cfg_load,
    input  ready0, ready1, write_enable, data_in, full_tresh, cfg_pending, grant, cnt0, cnt1
  );
  modport slave (
    input  valid0, data0, valid1, data1, fifo_full, fifo_empty, cfg_thresh, cfg_load,
    output ready0, ready1, write_enable, data_in, full_tresh, cfg_pending, grant, cnt0, cnt1
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-bounded sharing of one FIFO write port
module fifo_write_arbiter #(
  parameter int MAX_BURST      = 4,
  parameter int DEFAULT_THRESH = 31
) (
  input logic clock,
  input logic reset,
  fifo_write_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10;
  logic [1:0] state, nxt, other;
  logic [3:0] burst_cnt, burst_nxt;
  logic       last_served, sel, vx, vo, acc, burst_end, apply;
  logic [5:0] pend_val, clamp;
  always_comb begin
    sel              = state == G1;
    vx               = sel ? bus.valid1 : bus.valid0;
    vo               = sel ? bus.valid0 : bus.valid1;
    other            = sel ? G0 : G1;
    acc              = state != IDLE && vx && !bus.fifo_full;
    burst_end        = acc && burst_cnt == 4'(MAX_BURST - 1);
    bus.ready0       = state == G0 && !bus.fifo_full;
    bus.ready1       = state == G1 && !bus.fifo_full;
    bus.write_enable = acc;
    bus.data_in      = state == G0 ? bus.data0 : state == G1 ? bus.data1 : 8'h00;
    bus.grant        = state;
    // tie in IDLE goes to whoever was not served last
    nxt = state == IDLE ? (bus.valid0 && (!bus.valid1 || last_served) ? G0 : bus.valid1 ? G1 : IDLE)
        : !vx ? (vo ? other : IDLE)
        : (burst_end && vo) ? other : state;
    burst_nxt = (state == IDLE || !vx || burst_end) ? 4'd0 : burst_cnt + 4'(acc);
    clamp = bus.cfg_thresh == 6'd0 ? 6'd1 : bus.cfg_thresh > 6'd31 ? 6'd31 : bus.cfg_thresh;
    apply = bus.cfg_pending && bus.fifo_empty && !acc;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state           <= IDLE;
      burst_cnt       <= 4'd0;
      last_served     <= 1'b1;
      bus.cnt0        <= 16'd0;
      bus.cnt1        <= 16'd0;
      bus.full_tresh  <= 6'(DEFAULT_THRESH);
      bus.cfg_pending <= 1'b0;
      pend_val        <= 6'(DEFAULT_THRESH);
    end else begin
      state           <= nxt;
      burst_cnt       <= burst_nxt;
      last_served     <= acc ? sel : last_served;
      bus.cnt0        <= bus.cnt0 + 16'(acc && !sel);
      bus.cnt1        <= bus.cnt1 + 16'(acc && sel);
      bus.full_tresh  <= apply ? pend_val : bus.full_tresh;
      bus.cfg_pending <= bus.cfg_load || (bus.cfg_pending && !apply);
      pend_val        <= bus.cfg_load ? clamp : pend_val;
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed stimulus with a scoreboard of expected FIFO writes
module tb_fifo_write_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  fifo_write_arbiter_if bus();
  fifo_write_arbiter #(.MAX_BURST(4), .DEFAULT_THRESH(31)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int checks = 0, failures = 0;
  logic [7:0] q0[$], q1[$];
  logic [9:0] exp_q[$];
  logic en0 = 1'b0, en1 = 1'b0, a0, a1;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, got, want);
    end
  endtask
  always @(negedge clock)
    if (!reset && bus.write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write got=%0h want=none", {bus.grant, bus.data_in});
      end else chk("write", 32'({bus.grant, bus.data_in}), 32'(exp_q.pop_front()));
    end
  always begin
    @(negedge clock);
    a0 = bus.valid0 & bus.ready0;
    a1 = bus.valid1 & bus.ready1;
    @(posedge clock);
    #1;
    if (a0 && q0.size() > 0) q0.delete(0);
    if (a1 && q1.size() > 0) q1.delete(0);
    bus.valid0 = en0 && q0.size() > 0;
    bus.data0  = q0.size() > 0 ? q0[0] : 8'h00;
    bus.valid1 = en1 && q1.size() > 0;
    bus.data1  = q1.size() > 0 ? q1[0] : 8'h00;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask
  task automatic pushx(input logic [1:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask
  task automatic drain(input string n);
    for (int i = 0; i < 200; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !bus.write_enable) break;
      cyc(1);
    end
    chk(n, 32'(q0.size() + q1.size() + exp_q.size()), 32'd0);
    cyc(2);
  endtask
  task automatic wait_cnt(input string n, input logic w, input logic [15:0] v);
    for (int i = 0; i < 200; i++) begin
      if ((w ? bus.cnt1 : bus.cnt0) == v) break;
      cyc(1);
    end
    chk(n, 32'(w ? bus.cnt1 : bus.cnt0), 32'(v));
  endtask
  task automatic flush();
    q0.delete();
    q1.delete();
    exp_q.delete();
    en0 = 1'b0;
    en1 = 1'b0;
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_we"}, 32'(bus.write_enable), 32'd0);
    chk({n, "_grant"}, 32'(bus.grant), 32'd0);
    chk({n, "_cnt"}, 32'({bus.cnt0, bus.cnt1}), 32'd0);
    chk({n, "_tresh"}, 32'(bus.full_tresh), 32'd31);
    chk({n, "_pend"}, 32'(bus.cfg_pending), 32'd0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    flush();
    #1;
    chk_reset("reset");
    cyc(2);
    chk("reset_rdy", 32'({bus.ready0, bus.ready1, bus.data_in}), 32'd0);
    reset = 1'b0;
    cyc(1);
  endtask
  task automatic cfg(input logic [5:0] v);
    bus.cfg_thresh = v;
    bus.cfg_load = 1'b1;
    cyc(1);
    bus.cfg_load = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    bus.valid0 = 1'b0; bus.valid1 = 1'b0; bus.data0 = 8'h00; bus.data1 = 8'h00;
    bus.fifo_full = 1'b0; bus.fifo_empty = 1'b0; bus.cfg_thresh = 6'd0; bus.cfg_load = 1'b0;
    cyc(2);
    do_reset();
    // single producer: IDLE bubble, then 6 back-to-back beats across a burst restart
    for (int i = 0; i < 6; i++) begin q0.push_back(8'hA0 + 8'(i)); pushx(2'b01, 8'hA0 + 8'(i)); end
    en0 = 1'b1;
    cyc(1);
    @(negedge clock);
    chk("t1_idle", 32'({bus.grant, bus.write_enable, bus.ready0}), 32'd0);
    @(negedge clock);
    chk("t1_first", 32'({bus.grant, bus.write_enable}), 32'b011);
    for (int i = 1; i < 6; i++) begin @(negedge clock); chk("t1_stream", 32'(bus.write_enable), 32'd1); end
    cyc(1);
    drain("t1_drain");
    chk("t1_cnt", 32'({bus.cnt0, bus.cnt1}), {16'd6, 16'd0});
    // both producers continuously valid: alternating bursts of 4, producer 0 first
    do_reset();
    for (int i = 0; i < 8; i++) begin q0.push_back(8'h10 + 8'(i)); q1.push_back(8'h20 + 8'(i)); end
    for (int i = 0; i < 4; i++) pushx(2'b01, 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) pushx(2'b10, 8'h20 + 8'(i));
    for (int i = 4; i < 8; i++) pushx(2'b01, 8'h10 + 8'(i));
    for (int i = 4; i < 8; i++) pushx(2'b10, 8'h20 + 8'(i));
    en0 = 1'b1; en1 = 1'b1;
    drain("t2_drain");
    chk("t2_cnt", 32'({bus.cnt0, bus.cnt1}), {16'd8, 16'd8});
    // full stall in G1 must not advance the burst count
    en0 = 1'b0; en1 = 1'b1;
    for (int i = 0; i < 6; i++) q1.push_back(8'h30 + 8'(i));
    q0.push_back(8'h40);
    for (int i = 0; i < 4; i++) pushx(2'b10, 8'h30 + 8'(i));
    pushx(2'b01, 8'h40);
    pushx(2'b10, 8'h34);
    pushx(2'b10, 8'h35);
    wait_cnt("t3_wait", 1'b1, 16'd10);
    bus.fifo_full = 1'b1;
    en0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t3_stall", 32'({bus.grant, bus.write_enable, bus.ready1}), 32'b1000);
    end
    cyc(1);
    bus.fifo_full = 1'b0;
    @(negedge clock);
    chk("t3_resume", 32'({bus.write_enable, bus.data_in}), 32'h132);
    cyc(1);
    drain("t3_drain");
    chk("t3_cnt", 32'({bus.cnt0, bus.cnt1}), {16'd9, 16'd14});
    // threshold configuration
    cfg(6'd8);
    @(negedge clock);
    chk("t4_pend", 32'({bus.cfg_pending, bus.full_tresh}), {25'd0, 1'b1, 6'd31});
    cyc(2);
    chk("t4_hold", 32'({bus.cfg_pending, bus.full_tresh}), {25'd0, 1'b1, 6'd31});
    bus.fifo_empty = 1'b1;
    cyc(1);
    chk("t4_apply8", 32'({bus.cfg_pending, bus.full_tresh}), 32'd8);
    cfg(6'd0);
    chk("t4_pend0", 32'(bus.cfg_pending), 32'd1);
    cyc(1);
    chk("t4_clamp_lo", 32'({bus.cfg_pending, bus.full_tresh}), 32'd1);
    cfg(6'd40);
    cyc(1);
    chk("t4_clamp_hi", 32'({bus.cfg_pending, bus.full_tresh}), 32'd31);
    bus.fifo_empty = 1'b0;
    cfg(6'd5);
    bus.fifo_empty = 1'b1;
    cfg(6'd12);
    chk("t4_coincide", 32'({bus.cfg_pending, bus.full_tresh}), {25'd0, 1'b1, 6'd5});
    cyc(1);
    chk("t4_after", 32'({bus.cfg_pending, bus.full_tresh}), 32'd12);
    bus.fifo_empty = 1'b0;
    // valid0 released mid-burst: same-edge hand-over to producer 1
    q0.push_back(8'h50); q0.push_back(8'h51); q0.push_back(8'h52);
    q1.push_back(8'h60); q1.push_back(8'h61);
    pushx(2'b01, 8'h50); pushx(2'b01, 8'h51); pushx(2'b10, 8'h60); pushx(2'b10, 8'h61);
    en0 = 1'b1; en1 = 1'b1;
    wait_cnt("t6_wait", 1'b0, 16'd10);
    en0 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("t6_drop", 32'({bus.grant, bus.write_enable}), 32'b010);
    @(negedge clock);
    chk("t6_switch", 32'({bus.grant, bus.write_enable, bus.data_in}), {21'd0, 2'b10, 1'b1, 8'h60});
    cyc(1);
    q0.delete();
    drain("t6_drain");
    chk("t6_cnt", 32'({bus.cnt0, bus.cnt1}), {16'd11, 16'd16});
    // reset in the middle of a G0 burst
    for (int i = 0; i < 6; i++) q0.push_back(8'h70 + 8'(i));
    pushx(2'b01, 8'h70); pushx(2'b01, 8'h71);
    en0 = 1'b1;
    wait_cnt("t5_wait", 1'b0, 16'd13);
    reset = 1'b1;
    #1;
    chk_reset("t5_midreset");
    chk("t5_seen", 32'(exp_q.size()), 32'd0);
    flush();
    cyc(2);
    reset = 1'b0;
    cyc(1);
    q0.push_back(8'h80); q1.push_back(8'h90);
    pushx(2'b01, 8'h80); pushx(2'b10, 8'h90);
    en0 = 1'b1; en1 = 1'b1;
    drain("t5_tie");
    chk("t5_cnt", 32'({bus.cnt0, bus.cnt1}), {16'd1, 16'd1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
